// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Number of CALC cycles per division.
    function automatic int unsigned num_cycles(input int unsigned width, input int unsigned steps);
        return width / steps;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_unsigned_divider_step.sv
// One combinational restoring-division step on the {rem, dq} pair.
module div_restoring_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dq,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dq_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    // rem < divisor on entry, so a kept difference always fits in WIDTH bits.
    always_comb begin
        shifted  = {rem, dq[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        borrow   = diff[WIDTH];
        rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        dq_next  = {dq[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/seq_unsigned_divider.sv
// Multi-cycle unsigned restoring divider with start/done handshake and divide-by-zero flag.
module seq_unsigned_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned N  = num_cycles(WIDTH, STEPS_PER_CYCLE);
    localparam int unsigned CW = cnt_width(N);

    if (!(WIDTH >= 2 && WIDTH <= 32 &&
          (STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4) &&
          (WIDTH % STEPS_PER_CYCLE) == 0)) begin : g_bad_params
        $error("seq_unsigned_divider: illegal WIDTH/STEPS_PER_CYCLE combination");
    end

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dq_q;
    logic [WIDTH-1:0] dvs_q;
    logic             dbz_q;

    logic [WIDTH-1:0] rem_chain [0:STEPS_PER_CYCLE];
    logic [WIDTH-1:0] dq_chain  [0:STEPS_PER_CYCLE];

    assign rem_chain[0] = rem_q;
    assign dq_chain[0]  = dq_q;

    // Unrolled restoring steps retired in a single clock.
    for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
        div_restoring_step #(.WIDTH(WIDTH)) u_step (
            .rem      (rem_chain[i]),
            .dq       (dq_chain[i]),
            .divisor  (dvs_q),
            .rem_next (rem_chain[i+1]),
            .dq_next  (dq_chain[i+1])
        );
    end

    // A zero divisor spends one CALC cycle so its latency is one cycle past the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rem_q         <= '0;
            dq_q          <= '0;
            dvs_q         <= '0;
            dbz_q         <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        dvs_q  <= divisor_i;
                        dq_q   <= dividend_i;
                        rem_q  <= '0;
                        busy_o <= 1'b1;
                        state  <= CALC;
                        if (divisor_i == '0) begin
                            cnt   <= CW'(1);
                            dbz_q <= 1'b1;
                        end else begin
                            cnt   <= CW'(N);
                            dbz_q <= 1'b0;
                        end
                    end else begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= rem_chain[STEPS_PER_CYCLE];
                    dq_q  <= dq_chain[STEPS_PER_CYCLE];
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        if (dbz_q) begin
                            quotient_o    <= '1;
                            remainder_o   <= dq_q;
                            div_by_zero_o <= 1'b1;
                        end else begin
                            quotient_o    <= dq_chain[STEPS_PER_CYCLE];
                            remainder_o   <= rem_chain[STEPS_PER_CYCLE];
                            div_by_zero_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Directed and table-driven checks of the sequential divider at 8/1 and 16/2 configurations.
module tb_seq_unsigned_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 1'b0;
    logic [7:0]  dd8 = '0, dv8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  q8, r8;

    logic        start16 = 1'b0;
    logic [15:0] dd16 = '0, dv16 = '0;
    logic        busy16, done16, dbz16;
    logic [15:0] q16, r16;

    seq_unsigned_divider #(.WIDTH(8), .STEPS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .dividend_i(dd8), .divisor_i(dv8),
        .busy_o(busy8), .done_o(done8), .quotient_o(q8), .remainder_o(r8),
        .div_by_zero_o(dbz8)
    );

    seq_unsigned_divider #(.WIDTH(16), .STEPS_PER_CYCLE(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start16), .dividend_i(dd16), .divisor_i(dv16),
        .busy_o(busy16), .done_o(done16), .quotient_o(q16), .remainder_o(r16),
        .div_by_zero_o(dbz16)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns once done is seen, in the DONE cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat,
                        output logic busy_ok);
        start8 = 1'b1; dd8 = a; dv8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; dd8 = 'x; dv8 = 'x;
        lat = 0; busy_ok = 1'b1;
        while (!done8 && lat < 40) begin
            if (lat >= 1 && !busy8) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, output int lat);
        start16 = 1'b1; dd16 = a; dv16 = b;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int         lat;
        logic       bok;
        logic [15:0] ra, rb;

        vecs[0]  = '{8'd100, 8'd5,   8'd20,  8'd0,   1'b0, 8};
        vecs[1]  = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 8};
        vecs[2]  = '{8'd3,   8'd200, 8'd0,   8'd3,   1'b0, 8};
        vecs[3]  = '{8'd200, 8'd1,   8'd200, 8'd0,   1'b0, 8};
        vecs[4]  = '{8'd7,   8'd0,   8'hFF,  8'd7,   1'b1, 1};
        vecs[5]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 8};
        vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 8};
        vecs[7]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
        vecs[8]  = '{8'd128, 8'd0,   8'hFF,  8'd128, 1'b1, 1};
        vecs[9]  = '{8'd17,  8'd4,   8'd4,   8'd1,   1'b0, 8};
        vecs[10] = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0, 8};

        #12;
        chk("reset_busy", 32'(busy8), 0);
        chk("reset_done", 32'(done8), 0);
        chk("reset_q", 32'(q8), 0);
        chk("reset_r", 32'(r8), 0);
        chk("reset_dbz", 32'(dbz8), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run8(vecs[i].a, vecs[i].b, lat, bok);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_q", i), 32'(q8), 32'(vecs[i].q));
            chk($sformatf("v%0d_r", i), 32'(r8), 32'(vecs[i].r));
            chk($sformatf("v%0d_dbz", i), 32'(dbz8), 32'(vecs[i].dbz));
            chk($sformatf("v%0d_busy", i), 32'(bok), 1);
            @(posedge clk); #1;
        end

        // Outputs hold in IDLE and done is a single pulse.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", 32'(done8), 0);
        chk("hold_q", 32'(q8), 2);
        chk("hold_busy", 32'(busy8), 0);

        // Back-to-back: second start issued in the DONE cycle of the first.
        run8(8'd100, 8'd7, lat, bok);
        chk("b2b1_lat", 32'(lat), 8);
        chk("b2b1_q", 32'(q8), 14);
        chk("b2b1_r", 32'(r8), 2);
        run8(8'd50, 8'd6, lat, bok);
        chk("b2b2_lat", 32'(lat), 8);
        chk("b2b2_q", 32'(q8), 8);
        chk("b2b2_r", 32'(r8), 2);
        @(posedge clk); #1;

        // Start pulsed mid-CALC with different operands must be ignored.
        start8 = 1'b1; dd8 = 8'd100; dv8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; dd8 = 8'd9; dv8 = 8'd0;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 4;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("midstart_lat", 32'(lat), 8);
        chk("midstart_q", 32'(q8), 14);
        chk("midstart_r", 32'(r8), 2);
        chk("midstart_dbz", 32'(dbz8), 0);
        @(posedge clk); #1;
        chk("midstart_no_restart", 32'(busy8), 0);

        // Asynchronous reset four cycles into 99/9.
        start8 = 1'b1; dd8 = 8'd99; dv8 = 8'd9;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy8), 0);
        chk("arst_q", 32'(q8), 0);
        chk("arst_r", 32'(r8), 0);
        chk("arst_dbz", 32'(dbz8), 0);
        bok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done8) bok = 1'b0;
        end
        chk("arst_no_done", 32'(bok), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run8(8'd99, 8'd9, lat, bok);
        chk("post_rst_lat", 32'(lat), 8);
        chk("post_rst_q", 32'(q8), 11);
        chk("post_rst_r", 32'(r8), 0);
        @(posedge clk); #1;

        // Wide configuration, two steps per clock.
        run16(16'd60000, 16'd7, lat);
        chk("w16_lat", 32'(lat), 8);
        chk("w16_q", 32'(q16), 8571);
        chk("w16_r", 32'(r16), 3);
        chk("w16_dbz", 32'(dbz16), 0);
        @(posedge clk); #1;
        run16(16'd1234, 16'd0, lat);
        chk("w16_dbz_lat", 32'(lat), 1);
        chk("w16_dbz_q", 32'(q16), 32'hFFFF);
        chk("w16_dbz_r", 32'(r16), 1234);
        chk("w16_dbz_flag", 32'(dbz16), 1);
        @(posedge clk); #1;

        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(1, 65535));
            run16(ra, rb, lat);
            chk($sformatf("rnd%0d_%0d/%0d", k, ra, rb),
                {q16, r16}, {ra / rb, ra % rb});
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
